mac_group_accum: RTL and testbench

//  Parametrised successor of the grouped int MAC array: per-group dot products over contiguous lane ranges,

---
 rtl/mac_group_accum.sv | 172 +++++++++++++++++
 tb/tb_mac_group_accum.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_group_accum.sv
// Grouped int MAC: per-group dot products over contiguous lane ranges, K-tiled accumulation with bias and saturation.
// Latency: capture -> multiply -> reduce -> accumulate, out_valid 3 edges after the in_last beat is taken.
// Backpressure: a held result (out_valid & !out_ready) freezes every stage and drops in_ready.
module mac_group_accum #(
  parameter int NUM_LANES         = 64,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_GROUPS        = 8,
  parameter int MAC_BIT_PER_GROUP = 7,
  parameter int ACC_WIDTH         = 32,
  localparam int NG_W             = $clog2(MAX_GROUPS + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_first,
  input  logic                                    in_last,
  input  logic                                    signed_mode,
  input  logic [NG_W-1:0]                         num_groups,
  input  logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] num_macs_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]         data,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]         weight,
  input  logic [MAX_GROUPS*ACC_WIDTH-1:0]         bias,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [MAX_GROUPS*ACC_WIDTH-1:0]         mac_out,
  output logic [NG_W-1:0]                         num_groups_o,
  output logic [MAX_GROUPS-1:0]                   sat_o,
  output logic                                    busy_o
);
  localparam int PROD_W = 2*DATA_WIDTH + 1;
  localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);
  localparam int POS_W  = MAC_BIT_PER_GROUP + $clog2(MAX_GROUPS) + 1;
  localparam int MB     = MAC_BIT_PER_GROUP;
  localparam int AW     = ACC_WIDTH;

  typedef struct packed {
    logic                     first;
    logic                     last;
    logic [NG_W-1:0]          ng;
    logic [MAX_GROUPS*AW-1:0] bias;
  } acc_cfg_t;

  typedef struct packed {
    acc_cfg_t                 acc;
    logic [MAX_GROUPS*MB-1:0] macs;
  } beat_cfg_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                          state;
  logic                            en;
  logic                            s0_vld, s1_vld, s2_vld;
  logic                            s0_signed;
  logic [NUM_LANES*DATA_WIDTH-1:0] s0_data, s0_weight;
  beat_cfg_t                       s0_cfg, s1_cfg;
  acc_cfg_t                        s2_cfg;
  logic signed [PROD_W-1:0]        prod    [NUM_LANES];
  logic signed [PROD_W-1:0]        s1_prod [NUM_LANES];
  logic signed [SUM_W-1:0]         grp_sum [MAX_GROUPS];
  logic signed [SUM_W-1:0]         s2_sum  [MAX_GROUPS];
  logic [POS_W-1:0]                lane_start, lane_cnt;
  logic                            start_acc;
  logic [AW-1:0]                   base;
  logic signed [AW:0]              wide;
  logic [MAX_GROUPS*AW-1:0]        acc_nxt;
  logic [MAX_GROUPS-1:0]           ovf;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign busy_o    = s0_vld | s1_vld | s2_vld | (state != IDLE);
  // Any beat not continuing a live accumulation starts a fresh one, so a held result is never added to.
  assign start_acc = (state != ACCUM) || s2_cfg.first;

  function automatic logic signed [PROD_W-1:0] ext(input logic [DATA_WIDTH-1:0] v, input logic sgn);
    return {{(PROD_W-DATA_WIDTH){sgn & v[DATA_WIDTH-1]}}, v};
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      prod[i] = ext(s0_data[i*DATA_WIDTH +: DATA_WIDTH], s0_signed)
              * ext(s0_weight[i*DATA_WIDTH +: DATA_WIDTH], s0_signed);
  end

  always_comb begin
    lane_start = '0;
    lane_cnt   = '0;
    for (int g = 0; g < MAX_GROUPS; g++) begin
      grp_sum[g] = '0;
      lane_cnt   = POS_W'(s1_cfg.macs[g*MB +: MB]);
      if (g < int'(s1_cfg.acc.ng)) begin
        for (int i = 0; i < NUM_LANES; i++)
          if (POS_W'(i) >= lane_start && POS_W'(i) < lane_start + lane_cnt)
            grp_sum[g] = grp_sum[g] + SUM_W'(s1_prod[i]);
      end
      lane_start = lane_start + lane_cnt;
    end
  end

  // One extra bit of headroom; disagreeing top bits mean the add left the ACC range.
  always_comb begin
    base    = '0;
    wide    = '0;
    acc_nxt = '0;
    ovf     = '0;
    for (int g = 0; g < MAX_GROUPS; g++) begin
      if (!start_acc)        base = mac_out[g*AW +: AW];
      else if (s2_cfg.first) base = s2_cfg.bias[g*AW +: AW];
      else                   base = '0;
      wide   = $signed({base[AW-1], base}) + (AW+1)'(s2_sum[g]);
      ovf[g] = wide[AW] ^ wide[AW-1];
      if (!ovf[g])       acc_nxt[g*AW +: AW] = wide[AW-1:0];
      else if (wide[AW]) acc_nxt[g*AW +: AW] = {1'b1, {(AW-1){1'b0}}};
      else               acc_nxt[g*AW +: AW] = {1'b0, {(AW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (in_valid) begin
        s0_signed      <= signed_mode;
        s0_data        <= data;
        s0_weight      <= weight;
        s0_cfg.acc.first <= in_first;
        s0_cfg.acc.last  <= in_last;
        s0_cfg.acc.ng    <= num_groups;
        s0_cfg.acc.bias  <= bias;
        s0_cfg.macs      <= num_macs_i;
      end
      if (s0_vld) begin
        s1_prod <= prod;
        s1_cfg  <= s0_cfg;
      end
      if (s1_vld) begin
        s2_sum <= grp_sum;
        s2_cfg <= s1_cfg.acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld       <= 1'b0;
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      state        <= IDLE;
      out_valid    <= 1'b0;
      mac_out      <= '0;
      sat_o        <= '0;
      num_groups_o <= '0;
    end else if (en) begin
      s0_vld <= in_valid;
      s1_vld <= s0_vld;
      s2_vld <= s1_vld;
      if (s2_vld) begin
        mac_out <= acc_nxt;
        sat_o   <= (start_acc ? '0 : sat_o) | ovf;
        if (s2_cfg.last) begin
          state        <= DONE;
          out_valid    <= 1'b1;
          num_groups_o <= s2_cfg.ng;
        end else begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      end else if (state == DONE) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mac_group_accum.sv
// Randomized bench for mac_group_accum against an arithmetic reference model of grouped K-tiled dot products.
`timescale 1ns/1ps
module tb_mac_group_accum;
  localparam int NL  = 64;
  localparam int DW  = 8;
  localparam int MG  = 8;
  localparam int MB  = 7;
  localparam int AW  = 32;
  localparam int NGW = $clog2(MG + 1);
  localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW-1));

  logic              clk, rst;
  logic              in_valid, in_ready, in_first, in_last, signed_mode;
  logic [NGW-1:0]    num_groups;
  logic [MG*MB-1:0]  num_macs_i;
  logic [NL*DW-1:0]  data, weight;
  logic [MG*AW-1:0]  bias;
  logic              out_valid, out_ready;
  logic [MG*AW-1:0]  mac_out;
  logic [NGW-1:0]    num_groups_o;
  logic [MG-1:0]     sat_o;
  logic              busy_o;

  mac_group_accum #(.NUM_LANES(NL), .DATA_WIDTH(DW), .MAX_GROUPS(MG),
                    .MAC_BIT_PER_GROUP(MB), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
    .num_groups(num_groups), .num_macs_i(num_macs_i), .data(data), .weight(weight),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready), .mac_out(mac_out),
    .num_groups_o(num_groups_o), .sat_o(sat_o), .busy_o(busy_o));

  int n_chk, n_pass, rdy_pct;

  // Current beat being offered; the model reads the same values at acceptance.
  bit         b_first, b_last, b_sgn;
  int         b_ng;
  int         b_macs [MG];
  int         b_bias [MG];
  logic [7:0] b_data [NL];
  logic [7:0] b_weight [NL];

  typedef struct {
    logic [MG*AW-1:0] mac;
    logic [MG-1:0]    sat;
    logic [NGW-1:0]   ng;
  } exp_t;
  exp_t   exp_q [$];
  longint m_acc [MG];
  bit     m_sat [MG];
  bit     m_active;

  task automatic chk(input string tag, input logic [MG*AW-1:0] got, input logic [MG*AW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] w(input int v);
    return AW'(v);
  endfunction

  function automatic longint opv(input logic [7:0] x, input bit s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  task automatic model_accept();
    longint s, v, base;
    int     st;
    bit     start, ovf;
    exp_t   e;
    start = !m_active || b_first;
    for (int g = 0; g < MG; g++) begin
      s = 0;
      if (g < b_ng) begin
        st = 0;
        for (int h = 0; h < g; h++) st += b_macs[h];
        for (int l = st; l < st + b_macs[g] && l < NL; l++)
          s += opv(b_data[l], b_sgn) * opv(b_weight[l], b_sgn);
      end
      if (!start)       base = m_acc[g];
      else if (b_first) base = longint'(b_bias[g]);
      else              base = 0;
      v   = base + s;
      ovf = 0;
      if (v > MAXV) begin v = MAXV; ovf = 1; end
      else if (v < MINV) begin v = MINV; ovf = 1; end
      m_acc[g] = v;
      m_sat[g] = (start ? 1'b0 : m_sat[g]) | ovf;
    end
    if (b_last) begin
      for (int g = 0; g < MG; g++) begin
        e.mac[g*AW +: AW] = AW'(m_acc[g]);
        e.sat[g]          = m_sat[g];
      end
      e.ng = NGW'(b_ng);
      exp_q.push_back(e);
      m_active = 0;
    end else m_active = 1;
  endtask

  task automatic clear_beat();
    b_first = 0; b_last = 0; b_sgn = 0; b_ng = 0;
    for (int g = 0; g < MG; g++) begin b_macs[g] = 0; b_bias[g] = 0; end
    for (int l = 0; l < NL; l++) begin b_data[l] = '0; b_weight[l] = '0; end
  endtask

  task automatic fill(input logic [7:0] d, input logic [7:0] wt);
    for (int l = 0; l < NL; l++) begin b_data[l] = d; b_weight[l] = wt; end
  endtask

  // Called just after a rising edge; in_ready seen at the falling edge decides acceptance.
  task automatic send();
    in_first = b_first; in_last = b_last; signed_mode = b_sgn; num_groups = NGW'(b_ng);
    for (int g = 0; g < MG; g++) begin
      num_macs_i[g*MB +: MB] = MB'(b_macs[g]);
      bias[g*AW +: AW]       = b_bias[g];
    end
    for (int l = 0; l < NL; l++) begin
      data[l*DW +: DW]   = b_data[l];
      weight[l*DW +: DW] = b_weight[l];
    end
    in_valid = 1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept();
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
    end
    chk("send_timeout", in_ready, 1);
    in_valid = 0;
  endtask

  task automatic wait_result();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    chk("result_timeout", out_valid, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) begin @(posedge clk); #1; return; end
    end
    chk("drain_timeout", {busy_o, 32'(exp_q.size())}, 0);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_result", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("res_mac", mac_out, e.mac);
        chk("res_sat", sat_o, e.sat);
        chk("res_ng", num_groups_o, e.ng);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit imp;
    n_chk = 0; n_pass = 0; rdy_pct = 100; m_active = 0;
    rst = 0; in_valid = 0; in_first = 0; in_last = 0; signed_mode = 0;
    num_groups = '0; num_macs_i = '0; data = '0; weight = '0; bias = '0;
    clear_beat();
    repeat (3) @(posedge clk); #1;
    chk("rst_mac", mac_out, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_ng", num_groups_o, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("idle_rdy", in_ready, 1);

    // Single signed beat, latency to out_valid
    clear_beat();
    b_first = 1; b_last = 1; b_sgn = 1; b_ng = 1; b_macs[0] = 64; b_bias[0] = 5;
    fill(8'h01, 8'hFF);
    send();
    repeat (2) @(posedge clk); #1;
    chk("t1_lat_early", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat", out_valid, 1);
    chk("t1_g0", mac_out[AW-1:0], w(-59));

    // Four-beat K-tiling, two groups
    clear_beat();
    b_ng = 2; b_macs[0] = 3; b_macs[1] = 5; b_bias[1] = 10;
    fill(8'd2, 8'd3);
    for (int b = 0; b < 4; b++) begin
      b_first = (b == 0); b_last = (b == 3);
      send();
    end
    wait_result();
    chk("t2_g0", mac_out[AW-1:0], w(72));
    chk("t2_g1", mac_out[2*AW-1:AW], w(130));
    @(posedge clk); #1;

    // Long unsigned accumulation saturates
    clear_beat();
    b_ng = 1; b_macs[0] = 64;
    fill(8'hFF, 8'hFF);
    for (int b = 0; b < 1000; b++) begin
      b_first = (b == 0); b_last = (b == 999);
      send();
    end
    wait_result();
    chk("t3_sat", sat_o[0], 1);
    chk("t3_g0", mac_out[AW-1:0], w(32'h7FFF_FFFF));
    @(posedge clk); #1;

    // Overlapping lane ranges past the last lane, inactive groups
    clear_beat();
    b_first = 1; b_last = 1; b_ng = 2; b_macs[0] = 40; b_macs[1] = 40; b_macs[2] = 5;
    fill(8'd1, 8'd1);
    send();
    wait_result();
    chk("t6_g0", mac_out[AW-1:0], w(40));
    chk("t6_g1", mac_out[2*AW-1:AW], w(24));
    chk("t6_rest", mac_out[MG*AW-1:2*AW], 0);
    @(posedge clk); #1;
    drain();

    // Downstream stall with results queued
    rdy_pct = 0;
    repeat (2) @(posedge clk); #1;
    for (int j = 0; j < 5; j++) begin
      clear_beat();
      b_first = 1; b_last = 1; b_sgn = $urandom_range(1); b_ng = $urandom_range(1, 8);
      for (int g = 0; g < MG; g++) begin b_macs[g] = $urandom_range(0, 10); b_bias[g] = $urandom_range(0, 999); end
      for (int l = 0; l < NL; l++) begin b_data[l] = 8'($urandom); b_weight[l] = 8'($urandom); end
      if (j < 4) send();
    end
    fork
      send();
      begin
        wait_result();
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          chk("stall_rdy", in_ready, 0);
          chk("stall_head", mac_out, exp_q[0].mac);
        end
        rdy_pct = 100;
      end
    join
    drain();

    // Restart mid-accumulation drops the partial sum
    clear_beat();
    b_sgn = 1; b_ng = 2; b_macs[0] = 4; b_macs[1] = 4;
    fill(8'd1, 8'd2);
    b_bias[0] = 100; b_bias[1] = 100;
    b_first = 1; send();
    b_first = 0; send();
    b_bias[0] = 7; b_bias[1] = 7;
    b_first = 1; send();
    b_first = 0; b_last = 1; send();
    wait_result();
    chk("t5_g0", mac_out[AW-1:0], w(23));
    chk("t5_g1", mac_out[2*AW-1:AW], w(23));
    @(posedge clk); #1;
    drain();

    // Asynchronous reset in the middle of a job
    b_last = 0; b_first = 1; send();
    b_first = 0; send();
    chk("t5_busy", busy_o, 1);
    #2 rst = 0;
    #1;
    chk("arst_mac", mac_out, 0);
    chk("arst_sat", sat_o, 0);
    chk("arst_ng", num_groups_o, 0);
    chk("arst_vld", out_valid, 0);
    chk("arst_busy", busy_o, 0);
    exp_q.delete();
    m_active = 0;
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    clear_beat();
    b_last = 1; b_ng = 1; b_macs[0] = 10; b_bias[0] = 500;
    fill(8'd1, 8'd1);
    send();
    wait_result();
    chk("t5_implicit", mac_out[AW-1:0], w(10));
    @(posedge clk); #1;

    // Randomized jobs with random downstream backpressure
    rdy_pct = 70;
    for (int j = 0; j < 60; j++) begin
      k   = $urandom_range(1, 4);
      imp = ($urandom_range(9) == 0);
      for (int b = 0; b < k; b++) begin
        b_first = (b == 0 && !imp) || (b > 0 && $urandom_range(9) == 0);
        b_last  = (b == k - 1);
        b_sgn   = $urandom_range(1);
        b_ng    = $urandom_range(0, 9);
        for (int g = 0; g < MG; g++) begin
          b_macs[g] = ($urandom_range(3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
          b_bias[g] = ($urandom_range(7) == 0) ? int'($urandom) : $urandom_range(0, 2000000) - 1000000;
        end
        for (int l = 0; l < NL; l++) begin b_data[l] = 8'($urandom); b_weight[l] = 8'($urandom); end
        send();
      end
    end
    rdy_pct = 100;
    drain();
    chk("leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
